// File: rtl/framebuffer_wb_reader.sv
// framebuffer_wb_reader: streams a DDR-resident RGB888 frame to a pixel consumer, with Wishbone control
// Ports:
//   clk, rst_n             single clock, synchronous active-low reset
//   wb_*                   Wishbone slave: CTRL 0x0, STATUS 0x4, FRAME_COUNT 0x8, zero at 0xC
//   init_calib_complete    memory calibration done
//   app_*                  MIG-style user interface; only sequential 128-bit reads are issued
//   framebuffer_ready      prefetch FIFO primed, consumer may start pulling
//   framebuffer_pull       consumer requests one pixel
//   framebuffer_data/valid pixel {R,G,B}, registered one cycle after the pull
module framebuffer_wb_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          H_ACTIVE   = 1920,
    parameter int          V_ACTIVE   = 1080,
    parameter int          DW         = 128,
    parameter int          AW         = 28,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     wb_adr,
    input  logic [31:0]     wb_dat_w,
    input  logic [3:0]      wb_sel,
    input  logic            wb_we,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    output logic [31:0]     wb_dat_r,
    output logic            wb_ack,
    input  logic            init_calib_complete,
    output logic [AW-1:0]   app_addr,
    output logic [2:0]      app_cmd,
    output logic            app_en,
    input  logic            app_rdy,
    input  logic [DW-1:0]   app_rd_data,
    input  logic            app_rd_data_valid,
    output logic            app_wdf_wren,
    output logic            app_wdf_end,
    output logic [DW-1:0]   app_wdf_data,
    output logic [DW/8-1:0] app_wdf_mask,
    input  logic            app_wdf_rdy,
    output logic            framebuffer_ready,
    input  logic            framebuffer_pull,
    output logic [23:0]     framebuffer_data,
    output logic            framebuffer_valid
);
    localparam int WPR = H_ACTIVE / 4;
    localparam int XW  = WPR > 1 ? $clog2(WPR) : 1;
    localparam int YW  = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
    localparam int FA  = $clog2(FIFO_DEPTH);
    localparam int CW  = FA + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(FIFO_DEPTH / 2);
    localparam logic [XW-1:0] X_LAST  = XW'(WPR - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);

    logic          ctrl_en, underflow, drain;
    logic [31:0]   frame_count, reg_rd;
    logic [XW-1:0] iw, ow;
    logic [YW-1:0] ir, orow;
    logic [1:0]    slot;
    logic [CW-1:0] occ, outst, outst_n;
    logic [CW:0]   credit;
    logic [FA-1:0] wp, rp;
    logic [DW-1:0] fifo [FIFO_DEPTH];
    logic [DW-1:0] head;
    logic          wb_hit, wb_wr, uf_clr, accept, push, avail, serve, pop;
    logic          unused;

    assign app_cmd      = 3'b001;
    assign app_addr     = (AW'(ir) << 12) | (AW'(iw) << 3);
    assign app_wdf_wren = 1'b0;
    assign app_wdf_end  = 1'b0;
    assign app_wdf_data = '0;
    assign app_wdf_mask = '0;
    assign unused       = &{1'b0, app_wdf_rdy, wb_adr[1:0], wb_sel[3:1], wb_dat_w[31:3], wb_dat_w[1]};

    always_comb begin
        wb_hit  = wb_cyc & wb_stb & ~wb_ack & (wb_adr[31:4] == BASE_ADDR[31:4]);
        wb_wr   = wb_hit & wb_we;
        reg_rd  = wb_adr[3:2] == 2'd0 ? {31'd0, ctrl_en} :
                  wb_adr[3:2] == 2'd1 ? {29'd0, underflow, framebuffer_ready, init_calib_complete} :
                  wb_adr[3:2] == 2'd2 ? frame_count : 32'd0;
        uf_clr  = wb_wr & (wb_adr[3:2] == 2'd1) & wb_sel[0] & wb_dat_w[2];
        // FIFO words plus reads in flight must fit, so returns can never overflow
        credit  = {1'b0, occ} + {1'b0, outst};
        app_en  = ctrl_en & init_calib_complete & ~drain & (credit < DEPTH_C);
        accept  = app_en & app_rdy;
        // returns belonging to a disabled stream are counted but never stored
        push    = app_rd_data_valid & ctrl_en & ~drain;
        avail   = occ != '0;
        serve   = framebuffer_pull & avail;
        pop     = serve & (slot == 2'd3);
        outst_n = outst + CW'(accept) - CW'(app_rd_data_valid);
        head    = fifo[rp];
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wp] <= app_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ack            <= 1'b0;
            wb_dat_r          <= 32'd0;
            ctrl_en           <= 1'b0;
            underflow         <= 1'b0;
            drain             <= 1'b0;
            frame_count       <= 32'd0;
            outst             <= '0;
            occ               <= '0;
            wp                <= '0;
            rp                <= '0;
            iw                <= '0;
            ir                <= '0;
            ow                <= '0;
            orow              <= '0;
            slot              <= 2'd0;
            framebuffer_ready <= 1'b0;
            framebuffer_valid <= 1'b0;
            framebuffer_data  <= 24'd0;
        end else begin
            wb_ack   <= wb_hit;
            wb_dat_r <= (wb_hit & ~wb_we) ? reg_rd : 32'd0;
            if (wb_wr && wb_adr[3:2] == 2'd0 && wb_sel[0]) ctrl_en <= wb_dat_w[0];
            // a new underflow wins over a simultaneous clear
            underflow <= (framebuffer_pull & ~avail) | (underflow & ~uf_clr);
            outst     <= outst_n;
            // once disabled, hold off reissue until every stale read has returned
            drain     <= (drain | ~ctrl_en) & (outst_n != '0);
            framebuffer_valid <= serve;
            framebuffer_data  <= serve ? head[{slot, 5'd0} +: 24] : 24'd0;
            if (pop && ow == X_LAST && orow == Y_LAST) frame_count <= frame_count + 32'd1;
            if (!ctrl_en) begin
                iw                <= '0;
                ir                <= '0;
                ow                <= '0;
                orow              <= '0;
                slot              <= 2'd0;
                wp                <= '0;
                rp                <= '0;
                occ               <= '0;
                framebuffer_ready <= 1'b0;
            end else begin
                if (accept) begin
                    iw <= iw == X_LAST ? '0 : iw + 1'b1;
                    if (iw == X_LAST) ir <= ir == Y_LAST ? '0 : ir + 1'b1;
                end
                if (push) wp <= wp + 1'b1;
                if (pop) begin
                    rp <= rp + 1'b1;
                    ow <= ow == X_LAST ? '0 : ow + 1'b1;
                    if (ow == X_LAST) orow <= orow == Y_LAST ? '0 : orow + 1'b1;
                end
                if (serve) slot <= slot + 2'd1;
                occ               <= occ + CW'(push) - CW'(pop);
                framebuffer_ready <= framebuffer_ready | (occ >= HALF_C);
            end
        end
    end
endmodule

// File: tb/tb_framebuffer_wb_reader.sv
// tb_framebuffer_wb_reader: directed bench for framebuffer_wb_reader on an 8x2 frame with a latency-12 memory model
module tb_framebuffer_wb_reader;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]   wb_sel;
    logic         wb_we, wb_cyc, wb_stb, wb_ack;
    logic         init_calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_rd_data_valid;
    logic [127:0] app_rd_data, app_wdf_data;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [15:0]  app_wdf_mask;
    logic         framebuffer_ready, framebuffer_pull, framebuffer_valid;
    logic [23:0]  framebuffer_data;

    int n_cmp = 0, n_bad = 0;
    int rdy_mode = 1, cyc = 0, tb_out = 0, ret_cnt = 0;
    int exp_row = 0, exp_word = 0, p = 0, k;
    logic got, hold_pend = 1'b0;
    logic [27:0] hold_addr;
    logic [27:0] q_addr [$];
    int          q_due [$];

    logic [23:0] pix [16] = '{24'hAAAAAA, 24'h111111, 24'h111111, 24'h111111,
                             24'h555555, 24'h666666, 24'h777777, 24'h888888,
                             24'hCCCCCC, 24'h222222, 24'h222222, 24'h222222,
                             24'h333333, 24'hDDDDDD, 24'hEEEEEE, 24'hFFFFFF};

    framebuffer_wb_reader #(.H_ACTIVE(8), .V_ACTIVE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
        .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .framebuffer_ready(framebuffer_ready), .framebuffer_pull(framebuffer_pull),
        .framebuffer_data(framebuffer_data), .framebuffer_valid(framebuffer_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [127:0] mem_word(input logic [27:0] a);
        case (a)
            28'h0000: return {32'h11111111, 32'h11111111, 32'h11111111, 32'hAAAAAAAA};
            28'h0008: return {32'h88888888, 32'h77777777, 32'h66666666, 32'hEE555555};
            28'h1000: return {32'h22222222, 32'h22222222, 32'h22222222, 32'hCCCCCCCC};
            28'h1008: return {32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'h33333333};
            default:  return '1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory model: decides acceptance and drives returns half a cycle ahead of the DUT edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            tb_out = 0;
            hold_pend = 1'b0;
            app_rdy = 1'b0;
            app_rd_data_valid = 1'b0;
            app_rd_data = '0;
        end else begin
            cyc++;
            app_rdy = (rdy_mode == 1) || (rdy_mode == 2 && cyc % 2 == 0);
            if (app_en) begin
                if (hold_pend) check("hold_addr", 32'(app_addr), 32'(hold_addr));
                if (app_rdy) begin
                    check("seq_addr", 32'(app_addr), 32'((exp_row << 12) | (exp_word << 3)));
                    q_addr.push_back(app_addr);
                    q_due.push_back(cyc + 12);
                    tb_out++;
                    exp_word++;
                    if (exp_word == 2) begin
                        exp_word = 0;
                        exp_row = (exp_row + 1) % 2;
                    end
                    hold_pend = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    hold_addr = app_addr;
                end
            end else begin
                hold_pend = 1'b0;
            end
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                app_rd_data = mem_word(q_addr.pop_front());
                void'(q_due.pop_front());
                app_rd_data_valid = 1'b1;
                tb_out--;
                ret_cnt++;
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = '0;
            end
        end
    end

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output logic acked);
        wb_adr = adr;
        wb_we = we;
        wb_dat_w = dat;
        wb_sel = sel;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            tick(1);
            if (wb_ack) begin
                acked = 1'b1;
                rd = wb_dat_r;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we = 1'b0;
        tick(1);
    endtask

    task automatic wb_read(input logic [3:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic ok;
        wb_xfer(BASE + 32'(off), 1'b0, 32'd0, 4'hF, rd, ok);
        check({tag, "_ack"}, 32'(ok), 32'd1);
        check({tag, "_pulse"}, 32'(wb_ack), 32'd0);
        check(tag, rd, exp);
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel,
                            input string tag);
        logic [31:0] rd;
        logic ok;
        wb_xfer(BASE + 32'(off), 1'b1, dat, sel, rd, ok);
        check({tag, "_ack"}, 32'(ok), 32'd1);
        check({tag, "_pulse"}, 32'(wb_ack), 32'd0);
    endtask

    task automatic pull_pixels(input int n, input string tag);
        framebuffer_pull = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(1);
            check($sformatf("%s_valid%0d", tag, p), 32'(framebuffer_valid), 32'd1);
            check($sformatf("%s_pix%0d", tag, p), 32'(framebuffer_data), 32'(pix[p % 16]));
            p++;
        end
        framebuffer_pull = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        k = 0;
        while (!framebuffer_ready && k < 200) begin
            tick(1);
            k++;
        end
        check(tag, 32'(framebuffer_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic ok;
        rst_n = 1'b0;
        init_calib_complete = 1'b0;
        wb_adr = '0;
        wb_dat_w = '0;
        wb_sel = '0;
        wb_we = 1'b0;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        app_wdf_rdy = 1'b1;
        framebuffer_pull = 1'b0;
        tick(10);
        check("rst_wb_ack", 32'(wb_ack), 32'd0);
        check("rst_wb_dat_r", wb_dat_r, 32'd0);
        check("rst_app_en", 32'(app_en), 32'd0);
        check("rst_app_cmd", 32'(app_cmd), 32'd1);
        check("rst_app_addr", 32'(app_addr), 32'd0);
        check("rst_ready", 32'(framebuffer_ready), 32'd0);
        check("rst_valid", 32'(framebuffer_valid), 32'd0);
        check("rst_data", 32'(framebuffer_data), 32'd0);
        check("rst_wdf_wren", 32'(app_wdf_wren), 32'd0);
        rst_n = 1'b1;
        tick(1);

        wb_read(4'h4, 32'd0, "status_nocal");
        wb_read(4'h8, 32'd0, "frame_count0");
        wb_read(4'hC, 32'd0, "reg_c");
        wb_xfer(BASE + 32'h10, 1'b0, 32'd0, 4'hF, rd, ok);
        check("bad_adr_noack", 32'(ok), 32'd0);

        wb_write(4'h0, 32'd1, 4'hF, "ctrl_wr1");
        wb_read(4'h0, 32'd1, "ctrl_rb");
        wb_write(4'h0, 32'd0, 4'h0, "ctrl_nosel");
        wb_read(4'h0, 32'd1, "ctrl_sel_kept");
        k = 0;
        repeat (20) begin
            tick(1);
            if (app_en) k++;
        end
        check("no_en_uncal", 32'(k), 32'd0);

        init_calib_complete = 1'b1;
        #1;
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            if (app_en) got = 1'b1;
            else tick(1);
        end
        check("first_cmd", 32'(got), 32'd1);
        check("first_addr", 32'(app_addr), 32'd0);
        wait_ready("ready_rise");
        check("ready_beats", 32'(ret_cnt >= 8 && ret_cnt <= 9), 32'd1);
        wb_read(4'h4, 32'd3, "status_ready");

        pull_pixels(17, "frame");
        tick(1);
        check("idle_valid", 32'(framebuffer_valid), 32'd0);
        check("idle_data", 32'(framebuffer_data), 32'd0);
        wb_read(4'h8, 32'd1, "frame_count1");

        rdy_mode = 2;
        pull_pixels(48, "bp");
        wb_read(4'h8, 32'd4, "frame_count4");

        rdy_mode = 0;
        framebuffer_pull = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick(1);
            if (!framebuffer_valid) got = 1'b1;
            else begin
                check($sformatf("drain_pix%0d", p), 32'(framebuffer_data), 32'(pix[p % 16]));
                p++;
            end
        end
        check("underflow_seen", 32'(got), 32'd1);
        check("underflow_data", 32'(framebuffer_data), 32'd0);
        framebuffer_pull = 1'b0;
        tick(1);
        wb_read(4'h4, 32'd7, "status_uf");
        wb_write(4'h4, 32'd4, 4'hF, "uf_clear");
        wb_read(4'h4, 32'd3, "status_ufclr");

        rdy_mode = 1;
        tick(3);
        check("inflight_before_dis", 32'(tb_out > 0), 32'd1);
        wb_write(4'h0, 32'd0, 4'hF, "ctrl_dis");
        check("ready_dropped", 32'(framebuffer_ready), 32'd0);
        exp_row = 0;
        exp_word = 0;
        wb_write(4'h0, 32'd1, 4'hF, "ctrl_reen");
        check("inflight_at_reen", 32'(tb_out > 0), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (app_en) got = 1'b1;
            else tick(1);
        end
        check("reissue_seen", 32'(got), 32'd1);
        check("reissue_gate", 32'(tb_out), 32'd0);
        check("reissue_addr", 32'(app_addr), 32'd0);
        wait_ready("ready_again");
        p = 0;
        pull_pixels(5, "restart");

        rst_n = 1'b0;
        tick(2);
        check("mrst_ready", 32'(framebuffer_ready), 32'd0);
        check("mrst_app_en", 32'(app_en), 32'd0);
        check("mrst_app_addr", 32'(app_addr), 32'd0);
        exp_row = 0;
        exp_word = 0;
        rst_n = 1'b1;
        tick(1);
        wb_read(4'h0, 32'd0, "mrst_ctrl");
        wb_read(4'h8, 32'd0, "mrst_fc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
